// File: rtl/ones_counter_seq.sv
// ---------------------------------------------------------------------------
// ones_counter_seq
//
// Counts set bits (mode=0) or clear bits (mode=1) across all words of a frame
// and processes CHUNK_W bits per clock. A word is accepted in IDLE. It takes
// K = DATA_W/CHUNK_W COUNT cycles. The last word of a frame leads to DONE,
// where the frame total is held until the consumer takes it.
//
// Handshake: an input word transfers on a rising edge where in_valid=1 and
// in_ready=1. A result transfers on a rising edge where out_valid=1 and
// out_ready=1. The block never waits on in_valid while holding a result.
// Upstream keeps in_data/in_last/mode stable until the transfer edge.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data/in_last/mode valid
//   in_ready   : block accepts a word this cycle (high only in IDLE)
//   in_data    : word to count
//   in_last    : word is the final word of its frame
//   mode       : 0 = count ones, 1 = count zeros (sampled per word)
//   out_valid  : frame result available (high only in DONE)
//   out_ready  : consumer takes the result
//   out_count  : frame accumulator (shown in every state)
//   out_sat    : frame count saturated at 2^ACC_W-1
//   dbg_state  : current FSM state encoding (IDLE=0, COUNT=1, DONE=2)
// ---------------------------------------------------------------------------
module ones_counter_seq #(
    parameter int DATA_W  = 16,
    parameter int CHUNK_W = 4,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic              out_sat,
    output logic [1:0]        dbg_state
);

    localparam int K     = DATA_W / CHUNK_W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int CNT_W = $clog2(CHUNK_W + 1);

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                last_q,  last_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [ACC_W-1:0]    acc_q,   acc_d;
    logic                sat_q,   sat_d;

    logic [CNT_W-1:0]    chunk_cnt;
    logic [ACC_W:0]      sum_ext;

    function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int b = 0; b < CHUNK_W; b++) begin
            c = c + CNT_W'(v[b]);
        end
        return c;
    endfunction

    // The captured word is shifted right one chunk per COUNT cycle. The chunk
    // under count is therefore always the low CHUNK_W bits. This is the same
    // as selecting [i*CHUNK_W +: CHUNK_W] with the LSB chunk first, but it
    // avoids a variable-index mux.
    always_comb begin
        chunk_cnt = popcount(data_q[CHUNK_W-1:0]);
        // One extra bit so an overflow past ACC_MAX shows up as the carry.
        sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'(chunk_cnt);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Inverting on capture turns zero-counting into one-counting.
                    data_d  = mode ? ~in_data : in_data;
                    last_d  = in_last;
                    idx_d   = '0;
                    state_d = COUNT;
                end
            end

            COUNT: begin
                data_d = data_q >> CHUNK_W;
                idx_d  = idx_q + IDX_W'(1);

                // Once saturated, the accumulator stays pinned at max for
                // the rest of the frame.
                if (sat_q) begin
                    acc_d = ACC_MAX;
                end else if (sum_ext[ACC_W]) begin
                    acc_d = ACC_MAX;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum_ext[ACC_W-1:0];
                end

                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = last_q ? DONE : IDLE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_count = acc_q;
    assign out_sat   = sat_q;
    assign dbg_state = state_q;

endmodule

// File: doc/ones_counter_seq.md
ONES_COUNTER_SEQ -- requirements
Module: ones_counter_seq

Interface
REQ-001 Parameter DATA_W, default 16, input word width in bits.
REQ-002 Parameter CHUNK_W, default 4, bits counted per clock; DATA_W SHALL be an integer multiple of CHUNK_W, CHUNK_W >= 1.
REQ-003 Parameter ACC_W, default 16, frame accumulator width; ACC_W SHALL be >= clog2(DATA_W+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_data/in_last/mode valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  DATA_W  word to count.
REQ-009 in_last  input  1  word is final word of a frame.
REQ-010 mode  input  1  0 = count ones, 1 = count zeros.
REQ-011 out_valid  output  1  frame result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_count  output  ACC_W  frame count result.
REQ-014 out_sat  output  1  frame count saturated.

Function
REQ-015 FSM states SHALL be IDLE, COUNT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on edge with in_valid=1 (accept), SHALL capture in_data (inverted if mode=1), in_last, clear chunk index, go to COUNT; otherwise stay.
REQ-018 COUNT: each edge SHALL add popcount of chunk [i*CHUNK_W +: CHUNK_W] (LSB chunk first) to accumulator and increment index i.
REQ-019 K = DATA_W/CHUNK_W; after the edge processing chunk K-1, SHALL go to DONE if captured in_last=1, else to IDLE.
REQ-020 Latency: out_valid SHALL assert after the K-th edge following the accept edge of the last word; in_ready reasserts likewise for non-last words (throughput K+1 cycles/word).
REQ-021 Accumulator SHALL persist across words of a frame; mode is sampled per word.
REQ-022 Accumulation SHALL saturate at 2^ACC_W-1; once saturated, out_sat SHALL be 1 for remainder of frame and accumulator SHALL hold max.
REQ-023 DONE: out_count/out_sat SHALL hold stable while out_ready=0; on edge with out_ready=1 SHALL clear accumulator and out_sat and go to IDLE.
REQ-024 in_valid during COUNT or DONE SHALL be ignored (no capture); upstream holds word.
REQ-025 A frame of one word with in_last=1 SHALL be legal; a DATA_W=CHUNK_W build SHALL complete in one COUNT cycle.
REQ-026 out_count SHALL present the accumulator value in all states (only meaningful when out_valid=1).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, accumulator=0, index=0, out_sat=0, out_valid=0, out_count=0, in_ready=1 after release.
REQ-028 Reset asserted mid-COUNT or in DONE SHALL discard the partial/pending frame; no result emitted after release.

Verification (defaults unless stated, K=4)
REQ-029 mode=0, in_data=0xFFFF, in_last=1 -> out_valid after 4th edge past accept, out_count=16, out_sat=0.
REQ-030 mode=1, in_data=0x00F0, in_last=1 -> out_count=12.
REQ-031 Frame 0x0001 (last=0) then 0x0003 (last=1), mode=0 -> in_ready high between words, out_count=3.
REQ-032 ACC_W=5, frame 0xFFFF, 0xFFFF (last) mode=0 -> out_count=31, out_sat=1.
REQ-033 out_ready held 0 for 3 cycles in DONE -> out_count/out_valid stable, in_ready=0, in_valid ignored; release -> IDLE, next frame starts from 0.
REQ-034 rst_n pulsed low at 2nd COUNT cycle -> all outputs reset immediately; following frame 0x000F last -> out_count=4.
